load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: CPU request/response handshake to a byte-lane memory.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module load_store_unit #(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(READ_WAIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_error;

  logic        w_op_ok;
  logic        w_mis;
  logic        w_illegal;
  logic [31:0] w_addr;
  logic [4:0]  w_sh;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_lane;
  logic [31:0] w_ld;
  logic        w_last;

  // Classify the incoming request and align its address to the access size.
  always_comb begin
    w_op_ok = 1'b0;
    unique case (req_op)
      3'b000, 3'b001, 3'b011: w_op_ok = 1'b1;
      3'b100, 3'b101:         w_op_ok = !req_write;
      default:                w_op_ok = 1'b0;
    endcase
`ifdef MISALIGN_TRAP_EN
    w_mis = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
            ((req_op[1:0] == 2'b11) && (req_addr[1:0] != 2'b00));
`else
    w_mis = 1'b0;
`endif
    w_illegal = !w_op_ok || w_mis;
    w_addr = req_addr;
    if (req_op[1:0] == 2'b01)
      w_addr[0] = 1'b0;
    else if (req_op[1:0] == 2'b11)
      w_addr[1:0] = 2'b00;
  end

  // Byte-lane enables, store lane shift and load extraction.
  always_comb begin
    w_sh = {r_addr[1:0], 3'b000};
    w_be = 4'b1111;
    w_wd = r_wdata;
    unique case (r_op[1:0])
      2'b00: begin
        w_be = 4'b0001 << r_addr[1:0];
        w_wd = {24'b0, r_wdata[7:0]} << w_sh;
      end
      2'b01: begin
        w_be = 4'b0011 << r_addr[1:0];
        w_wd = {16'b0, r_wdata[15:0]} << w_sh;
      end
      default: begin
        w_be = 4'b1111;
        w_wd = r_wdata;
      end
    endcase
    w_lane = mem_readdata >> w_sh;
    unique case (r_op)
      3'b000:  w_ld = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ld = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ld = {24'b0, w_lane[7:0]};
      3'b101:  w_ld = {16'b0, w_lane[15:0]};
      default: w_ld = w_lane;
    endcase
  end

  assign w_last = (r_cnt == LAST);

  // Outputs decode straight from state so reset clears them at once.
  always_comb begin
    req_ready     = (r_state == S_IDLE);
    resp_valid    = (r_state == S_DONE);
    resp_rdata    = (r_state == S_DONE) ? r_rdata : 32'b0;
    resp_error    = (r_state == S_DONE) && r_error;
    mem_address   = 32'b0;
    mem_byte_en   = 4'b0;
    mem_write     = 1'b0;
    mem_writedata = 32'b0;
    if (r_state == S_ACCESS) begin
      mem_address = {r_addr[31:2], 2'b00};
      mem_byte_en = w_be;
      mem_write   = r_write && (r_cnt == 4'd0);
      if (r_write)
        mem_writedata = w_wd;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (req_valid)
          w_next = w_illegal ? S_DONE : S_ACCESS;
      S_ACCESS:
        if (r_write || w_last)
          w_next = S_DONE;
      S_DONE:
        if (resp_ready)
          w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Request latch, read wait counter and load result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write <= 1'b0;
      r_op    <= 3'b0;
      r_addr  <= 32'b0;
      r_wdata <= 32'b0;
      r_cnt   <= 4'b0;
      r_rdata <= 32'b0;
      r_error <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (req_valid) begin
        r_write <= req_write;
        r_op    <= req_op;
        r_addr  <= w_addr;
        r_wdata <= req_wdata;
        r_cnt   <= 4'b0;
        r_rdata <= 32'b0;
        r_error <= w_illegal;
      end
    end else if (r_state == S_ACCESS && !r_write) begin
      if (w_last) begin
        r_rdata <= w_ld;
        r_cnt   <= 4'b0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with READ_WAIT=3
// and a small byte-lane memory model.
module tb_load_store_unit;

  localparam int RW = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_op = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  logic [31:0] mem [0:15];

  int n_tot = 0;
  int n_bad = 0;

  int          t_lat;
  int          t_wcnt;
  int          t_acnt;
  int          t_hbad;
  logic [31:0] t_rd;
  logic        t_er;
  logic [31:0] t_addr;
  logic [3:0]  t_be;
  logic [31:0] t_wd;

  load_store_unit #(.READ_WAIT(RW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .mem_address   (mem_address),
    .mem_write     (mem_write),
    .mem_byte_en   (mem_byte_en),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata)
  );

  always #5 clk = ~clk;

  assign mem_readdata = mem[mem_address[5:2]];

  always @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 4; i++)
        if (mem_byte_en[i])
          mem[mem_address[5:2]][8*i +: 8] <= mem_writedata[8*i +: 8];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] d,
                      input int hold);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    t_lat = 0; t_wcnt = 0; t_acnt = 0; t_hbad = 0;
    t_addr = 32'b0; t_be = 4'b0; t_wd = 32'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_write) t_wcnt++;
      if (mem_byte_en != 4'b0) begin
        t_acnt++;
        if (t_acnt == 1) begin
          t_addr = mem_address;
          t_be   = mem_byte_en;
          t_wd   = mem_writedata;
        end
      end
      if (resp_valid) begin
        t_lat = i;
        break;
      end
    end
    chk("resp_seen", 32'(t_lat != 0), 32'd1);
    t_rd = resp_rdata;
    t_er = resp_error;
    repeat (hold) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== t_rd || resp_error !== t_er)
        t_hbad++;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  logic [2:0]  l_op  [4] = '{3'b001, 3'b101, 3'b100, 3'b000};
  logic [31:0] l_adr [4] = '{32'h1002, 32'h1002, 32'h1001, 32'h1003};
  logic [31:0] l_exp [4] = '{32'hFFFF8765, 32'h00008765,
                             32'h00000043, 32'hFFFFFF87};

  initial begin
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rerr", 32'(resp_error), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mwr", 32'(mem_write), 32'd0);
    chk("rst_be", 32'(mem_byte_en), 32'd0);
    chk("rst_maddr", mem_address, 32'd0);
    chk("rst_mwd", mem_writedata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    xfer(1'b1, 3'b011, 32'h1000, 32'h87654321, 0);
    chk("sw_lat", 32'(t_lat), 32'd2);
    chk("sw_be", 32'(t_be), 32'hF);
    chk("sw_wd", t_wd, 32'h87654321);
    chk("sw_wcnt", 32'(t_wcnt), 32'd1);

    xfer(1'b0, 3'b011, 32'h1000, 32'h0, 5);
    chk("lw_lat", 32'(t_lat), 32'(1 + RW));
    chk("lw_acnt", 32'(t_acnt), 32'(RW));
    chk("lw_addr", t_addr, 32'h1000);
    chk("lw_rd", t_rd, 32'h87654321);
    chk("lw_hold", 32'(t_hbad), 32'd0);
    chk("lw_wcnt", 32'(t_wcnt), 32'd0);

    for (int k = 0; k < 4; k++) begin
      xfer(1'b0, l_op[k], l_adr[k], 32'h0, 0);
      chk($sformatf("ld%0d_rd", k), t_rd, l_exp[k]);
      chk($sformatf("ld%0d_err", k), 32'(t_er), 32'd0);
    end

    xfer(1'b1, 3'b000, 32'h1002, 32'h000000AB, 0);
    chk("sb_lat", 32'(t_lat), 32'd2);
    chk("sb_addr", t_addr, 32'h1000);
    chk("sb_be", 32'(t_be), 32'h4);
    chk("sb_wd", t_wd, 32'h00AB0000);
    chk("sb_wcnt", 32'(t_wcnt), 32'd1);
    chk("sb_rd", t_rd, 32'd0);
    xfer(1'b0, 3'b011, 32'h1000, 32'h0, 0);
    chk("sb_after", t_rd, 32'h87AB4321);

    xfer(1'b1, 3'b001, 32'h1006, 32'h1234BEEF, 0);
    chk("sh_addr", t_addr, 32'h1004);
    chk("sh_be", 32'(t_be), 32'hC);
    chk("sh_wd", t_wd, 32'hBEEF0000);
    xfer(1'b0, 3'b101, 32'h1006, 32'h0, 0);
    chk("sh_after", t_rd, 32'h0000BEEF);

    xfer(1'b0, 3'b011, 32'h1001, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_err", 32'(t_er), 32'd1);
    chk("mis_lat", 32'(t_lat), 32'd1);
    chk("mis_acnt", 32'(t_acnt), 32'd0);
    chk("mis_rd", t_rd, 32'd0);
`else
    chk("mis_err", 32'(t_er), 32'd0);
    chk("mis_addr", t_addr, 32'h1000);
    chk("mis_rd", t_rd, 32'h87AB4321);
`endif

    xfer(1'b0, 3'b010, 32'h1000, 32'h0, 0);
    chk("op010_err", 32'(t_er), 32'd1);
    chk("op010_rd", t_rd, 32'd0);
    chk("op010_lat", 32'(t_lat), 32'd1);
    chk("op010_acnt", 32'(t_acnt), 32'd0);

    xfer(1'b1, 3'b100, 32'h1006, 32'h000000FF, 0);
    chk("sbu_err", 32'(t_er), 32'd1);
    chk("sbu_wcnt", 32'(t_wcnt), 32'd0);
    chk("sbu_acnt", 32'(t_acnt), 32'd0);
    xfer(1'b0, 3'b101, 32'h1006, 32'h0, 0);
    chk("sbu_after", t_rd, 32'h0000BEEF);

    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_op    = 3'b011;
    req_addr  = 32'h1000;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rs_mwr_pre", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rs_mwr", 32'(mem_write), 32'd0);
    chk("rs_ready", 32'(req_ready), 32'd1);
    chk("rs_be", 32'(mem_byte_en), 32'd0);
    chk("rs_maddr", mem_address, 32'd0);
    chk("rs_mwd", mem_writedata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    xfer(1'b0, 3'b011, 32'h1000, 32'h0, 0);
    chk("rs_mem", t_rd, 32'h87AB4321);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
